// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan sequencer and its neighbours: mux select/sample,
// frame output handshake, scan control and overrun status.
interface mux_scan_ctrl_if;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned FRAME_W = 8;

    logic               start;
    logic               cont;
    logic               y_in;
    logic [SEL_W-1:0]   sel;
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               frame_ready;
    logic               busy;
    logic               overrun;
    logic               clr_ovr;

    // Environment side: drives control, mux sample and downstream ready
    modport master (
        output start, cont, y_in, frame_ready, clr_ovr,
        input  sel, frame, frame_valid, busy, overrun
    );

    // Sequencer side
    modport slave (
        input  start, cont, y_in, frame_ready, clr_ovr,
        output sel, frame, frame_valid, busy, overrun
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: steps the select, waits SETTLE_CYC extra
// cycles per channel, samples y_in, and presents the packed byte on a
// valid/ready output with single-shot/continuous modes and sticky overrun.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.slave  bus
);
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FRAME_W = 8;

    localparam logic [CNT_W-1:0] CNT_LD   = CNT_W'(SETTLE_CYC);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    state_t               r_state;
    state_t               w_state;
    logic [SEL_W-1:0]     r_sel,   w_sel;
    logic [CNT_W-1:0]     r_cnt,   w_cnt;
    logic [FRAME_W-1:0]   r_shift, w_shift;
    logic [FRAME_W-1:0]   r_frame, w_frame;
    logic                 r_fv,    w_fv;
    logic                 r_busy,  w_busy;
    logic                 r_ovr,   w_ovr;
    logic                 w_out_free;

    // Output register can take a new byte if empty or being drained this cycle
    assign w_out_free = ~r_fv | bus.frame_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state;
    end

    // Next-state and next-register values
    always_comb begin
        w_state = r_state;
        w_sel   = r_sel;
        w_cnt   = r_cnt;
        w_shift = r_shift;
        w_frame = r_frame;
        w_fv    = r_fv & ~bus.frame_ready;
        w_ovr   = r_ovr & ~bus.clr_ovr;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state = ST_SETTLE;
                    w_sel   = '0;
                    w_cnt   = CNT_LD;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_shift[r_sel] = bus.y_in;
                    if (r_sel != SEL_LAST) begin
                        w_sel = r_sel + SEL_W'(1);
                        w_cnt = CNT_LD;
                    end else begin
                        w_state = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                w_sel = '0;
                if (w_out_free) begin
                    w_frame = r_shift;
                    w_fv    = 1'b1;
                    if (bus.cont) begin
                        w_state = ST_SETTLE;
                        w_cnt   = CNT_LD;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end else if (!bus.cont) begin
                    w_state = ST_HOLD;
                end else begin
                    // Continuous mode with a full output: drop the byte, flag it
                    w_ovr   = 1'b1;
                    w_state = ST_SETTLE;
                    w_cnt   = CNT_LD;
                end
            end
            ST_HOLD: begin
                if (bus.frame_ready) begin
                    w_frame = r_shift;
                    w_fv    = 1'b1;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_frame <= '0;
            r_fv    <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sel   <= w_sel;
            r_cnt   <= w_cnt;
            r_shift <= w_shift;
            r_frame <= w_frame;
            r_fv    <= w_fv;
            r_busy  <= w_busy;
            r_ovr   <= w_ovr;
        end
    end

    assign bus.sel         = r_sel;
    assign bus.frame       = r_frame;
    assign bus.frame_valid = r_fv;
    assign bus.busy        = r_busy;
    assign bus.overrun     = r_ovr;
endmodule
